// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains a byte FIFO: one read strobe per frame,
// never issued while the FIFO reports empty.
//
// state | meaning
// IDLE  | line high, waiting for fifo_empty to drop
// FETCH | one-cycle read strobe to the FIFO
// LOAD  | FIFO data settles, captured on the closing edge
// START | start bit (line low)
// DATA  | data bits, LSB first
// STOP  | stop bit (line high), tx_done on its final cycle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]            state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) state_n = S_FETCH;
            end
            S_FETCH: state_n = S_LOAD;
            S_LOAD: begin
                shreg_n = fifo_rd_data;
                cnt_n   = '0;
                idx_n   = '0;
                state_n = S_START;
            end
            S_START: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = S_DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = shreg >> 1;
                    if (idx == IDX_LAST) begin
                        idx_n   = '0;
                        state_n = S_STOP;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they change on the
    // same edge as the state and the serial line stays glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            fifo_rd_en <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            fifo_rd_en <= (state_n == S_FETCH);
            busy       <= (state_n != S_IDLE) && (state_n != S_FETCH);
            tx_done    <= (state_n == S_STOP) && (cnt_n == CNT_LAST);
            if (state_n == S_START)
                tx <= 1'b0;
            else if (state_n == S_DATA)
                tx <= shreg_n[0];
            else
                tx <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a FIFO model feeds it and a line decoder
// checks every frame against the bytes written, bit by bit and cycle by cycle.
module tb_fifo_uart_tx;

    localparam int C  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en, tx, busy, tx_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [DW-1:0] wr_mem [0:63];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    int  underflow = 0;
    bit  force_empty = 1'b0;
    int  rd_cyc[$];
    int  rd_dbl = 0;
    bit  prev_rd = 1'b0;

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    // FIFO model: data appears the cycle after the read pointer advances
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            if (wr_ptr == rd_ptr) underflow <= underflow + 1;
            else begin
                fifo_rd_data <= wr_mem[rd_ptr];
                rd_ptr       <= rd_ptr + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rd_cyc.push_back(cyc);
            if (prev_rd) rd_dbl++;
        end
        prev_rd = fifo_rd_en;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        wr_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_tx_low(output bit ok);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (tx !== 1'b0 && w < 3000);
        ok = (tx === 1'b0);
        if (!ok) chk("tx_fall_timeout", {31'd0, tx}, 32'd0);
    endtask

    // Decode one frame; expected bits come from wr_mem[idx] as start, LSB..MSB, stop
    task automatic recv_frame(input int idx, output int fall_cyc);
        bit            ok;
        logic [31:0]   s;
        logic [DW-1:0] exp_b, dec;
        logic          ebit;
        int            ndone, nbusy_low;
        logic          last_done;
        fall_cyc = -1;
        wait_tx_low(ok);
        if (!ok) return;
        fall_cyc  = cyc;
        exp_b     = wr_mem[idx];
        dec       = '0;
        ndone     = 0;
        nbusy_low = 0;
        last_done = 1'b0;
        for (int slot = 0; slot < DW + 2; slot++) begin
            s = '0;
            for (int i = 0; i < C; i++) begin
                if (slot != 0 || i != 0) @(negedge clk);
                s[i] = tx;
                if (tx_done) ndone++;
                if (!busy) nbusy_low++;
                last_done = tx_done;
                if (i == C / 2 && slot >= 1 && slot <= DW) dec[slot-1] = tx;
            end
            ebit = (slot == 0) ? 1'b0 : (slot == DW + 1) ? 1'b1 : exp_b[slot-1];
            chk($sformatf("frame%0d_slot%0d", idx, slot), s, ebit ? 32'((1 << C) - 1) : 32'd0);
        end
        chk($sformatf("frame%0d_byte", idx), {24'd0, dec}, {24'd0, exp_b});
        chk($sformatf("frame%0d_done_cnt", idx), ndone, 1);
        chk($sformatf("frame%0d_done_last", idx), {31'd0, last_done}, 32'd1);
        chk($sformatf("frame%0d_busy", idx), nbusy_low, 0);
        @(negedge clk);
        chk($sformatf("frame%0d_busy_after", idx), {31'd0, busy}, 32'd0);
        chk($sformatf("frame%0d_done_after", idx), {31'd0, tx_done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  f1, fa, fb, n0, bad, base, rel;
        bit  ok;

        // reset held with a non-empty FIFO
        @(negedge clk);
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", {31'd0, tx}, 32'd1);
            chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
        end
        reset = 1'b0;
        chk("rst_release_rd_en", {31'd0, fifo_rd_en}, 32'd0);

        // single byte
        recv_frame(0, f1);
        chk("a5_rd_pulses", rd_cyc.size(), 1);
        if (rd_cyc.size() >= 1) chk("a5_rd_to_fall", f1 - rd_cyc[0], 2);

        // back-to-back
        n0 = rd_cyc.size();
        push(8'h00);
        push(8'hFF);
        recv_frame(1, fa);
        recv_frame(2, fb);
        chk("b2b_period", fb - fa, 10 * C + 3);
        chk("b2b_rd_cnt", rd_cyc.size() - n0, 2);
        if (rd_cyc.size() >= n0 + 2) chk("b2b_rd_gap", rd_cyc[n0+1] - rd_cyc[n0], 10 * C + 3);

        // empty FIFO
        n0  = rd_cyc.size();
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("empty_rd", rd_cyc.size() - n0, 0);
        chk("empty_line", bad, 0);

        // random bytes with random arrival gaps, some landing mid-frame
        base = wr_ptr;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    repeat ($urandom_range(0, 60)) @(negedge clk);
                    push(DW'($urandom));
                end
            end
            begin
                for (int k = 0; k < 8; k++) recv_frame(base + k, fa);
            end
        join

        // reset during data bit 3 of 0x3C
        n0 = rd_cyc.size();
        push(8'h3C);
        wait_tx_low(ok);
        if (ok) begin
            repeat (C * 4 + 1) @(negedge clk);
            chk("mid_bit3_level", {31'd0, tx}, 32'd1);
            reset = 1'b1;
            @(negedge clk);
            chk("mid_rst_tx", {31'd0, tx}, 32'd1);
            chk("mid_rst_busy", {31'd0, busy}, 32'd0);
            chk("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            chk("mid_rst_done", {31'd0, tx_done}, 32'd0);
            @(negedge clk);
            reset = 1'b0;
            bad = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (tx !== 1'b1 || busy !== 1'b0) bad++;
            end
            chk("mid_rst_no_retx", bad, 0);
            chk("mid_rst_rd_cnt", rd_cyc.size() - n0, 1);
        end

        // fifo_empty forced high during DATA of 0x5A while 0x11 is still queued
        n0   = rd_cyc.size();
        base = wr_ptr;
        push(8'h5A);
        push(8'h11);
        fork
            recv_frame(base, fa);
            begin
                wait_tx_low(ok);
                repeat (2 * C) @(negedge clk);
                force_empty = 1'b1;
            end
        join
        repeat (30) @(negedge clk);
        chk("toggle_hold_rd_cnt", rd_cyc.size() - n0, 1);
        force_empty = 1'b0;
        rel = cyc;
        recv_frame(base + 1, fb);
        chk("toggle_rd_cnt", rd_cyc.size() - n0, 2);
        if (rd_cyc.size() >= n0 + 2) chk("toggle_rd_latency", rd_cyc[n0+1] - rel, 1);

        repeat (5) @(negedge clk);
        chk("underflow", underflow, 0);
        chk("rd_double_pulse", rd_dbl, 0);
        chk("total_rd", rd_cyc.size(), wr_ptr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
